// File: rtl/parking_pkg.sv
// ---------------------------------------------------------------------------
// parking_pkg
// Shared types and constants for the multi-gate parking occupancy block.
//   gate_state_t : per-gate direction FSM state, 3-bit, IDLE encoded as 0
//   MAX_GATES    : largest supported gate count; sizes the popcount adders
// ---------------------------------------------------------------------------
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        E1   = 3'd1,
        E2   = 3'd2,
        E3   = 3'd3,
        X1   = 3'd4,
        X2   = 3'd5,
        X3   = 3'd6
    } gate_state_t;

    localparam int MAX_GATES = 8;

endpackage

// File: rtl/parking_gate_fsm.sv
// ---------------------------------------------------------------------------
// parking_gate_fsm
// One gate: 2-FF synchronisers on both beam sensors, a direction FSM that
// recognises a full entry (ab: 10,11,01,00) or exit (ab: 01,11,10,00) and a
// registered one-cycle pulse for each completed pass.
// Ports:
//   clk_i      in   system clock
//   rst_ni     in   asynchronous active-low reset
//   sens_a_i   in   outer beam sensor, asynchronous to clk_i
//   sens_b_i   in   inner beam sensor, asynchronous to clk_i
//   entry_o    out  1-cycle pulse after the FSM samples the completing 00 (entry)
//   exit_o     out  1-cycle pulse after the FSM samples the completing 00 (exit)
//   state_o    out  current FSM state, for debug/checker binding
// ---------------------------------------------------------------------------
module parking_gate_fsm
    import parking_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sens_a_i,
    input  logic        sens_b_i,
    output logic        entry_o,
    output logic        exit_o,
    output gate_state_t state_o
);

    logic        a_meta_q, a_sync_q;
    logic        b_meta_q, b_sync_q;
    logic        entry_q, exit_q;
    gate_state_t state_q;
    logic [1:0]  ab;

    assign ab = {a_sync_q, b_sync_q};

    // The exit path is the entry path with the roles of a and b swapped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_meta_q <= 1'b0;
            a_sync_q <= 1'b0;
            b_meta_q <= 1'b0;
            b_sync_q <= 1'b0;
            state_q  <= IDLE;
            entry_q  <= 1'b0;
            exit_q   <= 1'b0;
        end else begin
            a_meta_q <= sens_a_i;
            a_sync_q <= a_meta_q;
            b_meta_q <= sens_b_i;
            b_sync_q <= b_meta_q;
            entry_q  <= 1'b0;
            exit_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ab == 2'b10)      state_q <= E1;
                    else if (ab == 2'b01) state_q <= X1;
                end
                E1: begin
                    if (ab == 2'b11)      state_q <= E2;
                    else if (ab != 2'b10) state_q <= IDLE;
                end
                E2: begin
                    case (ab)
                        2'b01:   state_q <= E3;
                        2'b10:   state_q <= E1;
                        2'b00:   state_q <= IDLE;
                        default: ;
                    endcase
                end
                E3: begin
                    case (ab)
                        2'b00: begin
                            state_q <= IDLE;
                            entry_q <= 1'b1;
                        end
                        2'b11:   state_q <= E2;
                        2'b10:   state_q <= IDLE;
                        default: ;
                    endcase
                end
                X1: begin
                    if (ab == 2'b11)      state_q <= X2;
                    else if (ab != 2'b01) state_q <= IDLE;
                end
                X2: begin
                    case (ab)
                        2'b10:   state_q <= X3;
                        2'b01:   state_q <= X1;
                        2'b00:   state_q <= IDLE;
                        default: ;
                    endcase
                end
                X3: begin
                    case (ab)
                        2'b00: begin
                            state_q <= IDLE;
                            exit_q  <= 1'b1;
                        end
                        2'b11:   state_q <= X2;
                        2'b01:   state_q <= IDLE;
                        default: ;
                    endcase
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign entry_o = entry_q;
    assign exit_o  = exit_q;
    assign state_o = state_q;

endmodule

// File: rtl/parking_occupancy_multi.sv
// ---------------------------------------------------------------------------
// parking_occupancy_multi
// Occupancy tracker for N_GATES gates sharing one saturating counter.
// Each gate's entry/exit pulses are popcounted, netted as a signed value and
// added to the count, which is then clamped to [0, CAPACITY]. A clamp means
// at least one event was dropped ("rejected").
// Optional feature macro: PARKING_ERR_FLAG_EN
//   defined   : err is a sticky rejected-event flag, cleared by err_clr
//               (a set in the same cycle as a clear wins)
//   undefined : err is tied low and err_clr is ignored
// Ports:
//   CLK          in   system clock
//   RST_N        in   asynchronous active-low reset
//   sens_a       in   [N_GATES] outer beam sensors
//   sens_b       in   [N_GATES] inner beam sensors
//   err_clr      in   synchronous clear of err
//   entry_pulse  out  [N_GATES] completed-entry pulses
//   exit_pulse   out  [N_GATES] completed-exit pulses
//   count        out  [CNT_W] current occupancy
//   full         out  count == CAPACITY
//   empty        out  count == 0
//   err          out  sticky rejected-event flag
// ---------------------------------------------------------------------------
module parking_occupancy_multi
    import parking_pkg::*;
#(
    parameter  int N_GATES  = 2,
    parameter  int CAPACITY = 7,
    localparam int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [N_GATES-1:0] sens_a,
    input  logic [N_GATES-1:0] sens_b,
    input  logic               err_clr,
    output logic [N_GATES-1:0] entry_pulse,
    output logic [N_GATES-1:0] exit_pulse,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               err
);

    localparam int PC_W  = $clog2(MAX_GATES + 1);
    localparam int NET_W = CNT_W + 4;
    localparam int SUM_W = NET_W + 1;
    localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

    // Debug view of every gate FSM; not consumed by the datapath.
    gate_state_t gate_state_unused [N_GATES];

    for (genvar g = 0; g < N_GATES; g++) begin : g_gate
        parking_gate_fsm u_fsm (
            .clk_i    (CLK),
            .rst_ni   (RST_N),
            .sens_a_i (sens_a[g]),
            .sens_b_i (sens_b[g]),
            .entry_o  (entry_pulse[g]),
            .exit_o   (exit_pulse[g]),
            .state_o  (gate_state_unused[g])
        );
    end

    logic [PC_W-1:0]         n_entry, n_exit;
    logic signed [NET_W-1:0] net;
    logic signed [SUM_W-1:0] sum;
    logic [CNT_W-1:0]        count_d, count_q;
    logic                    full_q, empty_q;
    logic                    rejected;

    always_comb begin
        n_entry = '0;
        n_exit  = '0;
        for (int g = 0; g < N_GATES; g++) begin
            n_entry = n_entry + PC_W'(entry_pulse[g]);
            n_exit  = n_exit + PC_W'(exit_pulse[g]);
        end
    end

    // Entries and exits on different gates cancel before the clamp.
    assign net = $signed(NET_W'(n_entry)) - $signed(NET_W'(n_exit));
    assign sum = $signed(SUM_W'(count_q)) + SUM_W'(net);

    always_comb begin
        count_d  = count_q;
        rejected = 1'b0;
        if (sum[SUM_W-1]) begin
            count_d  = '0;
            rejected = 1'b1;
        end else if (sum > CAP_S) begin
            count_d  = CNT_W'(CAPACITY);
            rejected = 1'b1;
        end else begin
            count_d  = sum[CNT_W-1:0];
        end
    end

    // Flags decode count_d so they line up with the registered count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(CAPACITY));
            empty_q <= (count_d == '0);
        end
    end

    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

`ifdef PARKING_ERR_FLAG_EN
    logic err_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else if (rejected) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    logic [1:0] unused_flag_inputs;

    assign unused_flag_inputs = {err_clr, rejected};
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_parking_occupancy_multi.sv
module tb_parking_occupancy_multi;

  localparam int N   = 2;
  localparam int CAP = 7;
  localparam int CW  = 3;
`ifdef PARKING_ERR_FLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  sens_a = '0;
  logic [N-1:0]  sens_b = '0;
  logic          err_clr = 1'b0;
  logic [N-1:0]  entry_pulse;
  logic [N-1:0]  exit_pulse;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          err;

  parking_occupancy_multi #(.N_GATES(N), .CAPACITY(CAP)) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .sens_a      (sens_a),
    .sens_b      (sens_b),
    .err_clr     (err_clr),
    .entry_pulse (entry_pulse),
    .exit_pulse  (exit_pulse),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .err         (err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // pulse monitor: running totals per gate, sampled on the falling edge
  int ent_tot [N] = '{0, 0};
  int ext_tot [N] = '{0, 0};

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (entry_pulse[g] === 1'b1) ent_tot[g] = ent_tot[g] + 1;
      if (exit_pulse[g] === 1'b1)  ext_tot[g] = ext_tot[g] + 1;
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // vector table
  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    bit           clr;
    int           hold;
    bit           chk;
    int           cnt;
    bit           e;
    int           ent0, ent1, ext0, ext1;
  } vec_t;

  vec_t tbl[$];
  int x_ent [N] = '{0, 0};
  int x_ext [N] = '{0, 0};

  task automatic push_row(input logic [N-1:0] a, input logic [N-1:0] b, input bit clr,
                          input int hold, input bit chk, input int cnt, input bit e);
    vec_t v;
    v.a = a; v.b = b; v.clr = clr; v.hold = hold; v.chk = chk;
    v.cnt = cnt; v.e = e & ERR_EN;
    v.ent0 = x_ent[0]; v.ent1 = x_ent[1]; v.ext0 = x_ext[0]; v.ext1 = x_ext[1];
    tbl.push_back(v);
  endtask

  // Full pass on every gate in em (entry) or xm (exit); entry ab = 10,11,01,00,
  // exit ab = 01,11,10,00. Checked on the closing 00 step.
  task automatic push_seq(input logic [N-1:0] em, input logic [N-1:0] xm,
                          input int cnt, input bit e);
    bit ea [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int s = 0; s < 4; s++) begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      for (int g = 0; g < N; g++) begin
        a[g] = (em[g] && ea[s]) || (xm[g] && eb[s]);
        b[g] = (em[g] && eb[s]) || (xm[g] && ea[s]);
      end
      if (s == 3) begin
        for (int g = 0; g < N; g++) begin
          x_ent[g] = x_ent[g] + int'(em[g]);
          x_ext[g] = x_ext[g] + int'(xm[g]);
        end
      end
      push_row(a, b, 1'b0, 5, (s == 3), cnt, e);
    end
  endtask

  // driver: apply inputs on a falling edge, hold, sample 1 time unit later
  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input bit clr, input int hold);
    @(negedge clk);
    sens_a  = a;
    sens_b  = b;
    err_clr = clr;
    repeat (hold) @(negedge clk);
    err_clr = 1'b0;
    #1;
  endtask

  task automatic check_flags(input string tag, input int cnt, input bit e);
    check({tag, "_count"}, 32'(count), 32'(cnt));
    check({tag, "_full"},  32'(full),  32'(cnt == CAP));
    check({tag, "_empty"}, 32'(empty), 32'(cnt == 0));
    check({tag, "_err"},   32'(err),   32'(e & ERR_EN));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int s_ent [N];
    int s_ext [N];

    // ---- reset with random sensors ----
    #1 rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sens_a = N'($urandom_range(0, 3));
      sens_b = N'($urandom_range(0, 3));
      #1;
      check($sformatf("rst%0d_count", i), 32'(count), 32'd0);
      check($sformatf("rst%0d_pulses", i), 32'({entry_pulse, exit_pulse}), 32'd0);
    end
    check_flags("rst", 0, 1'b0);
    @(negedge clk);
    sens_a = '0;
    sens_b = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table of directed sequences ----
    push_row(2'b00, 2'b00, 1'b0, 10, 1'b1, 0, 1'b0);     // idle after release
    push_seq(2'b01, 2'b00, 1, 1'b0);                     // gate0 entry
    push_seq(2'b11, 2'b00, 3, 1'b0);                     // both gates enter
    push_seq(2'b00, 2'b10, 2, 1'b0);                     // gate1 exit
    push_row(2'b01, 2'b00, 1'b0, 5, 1'b0, 2, 1'b0);      // gate0 aborted: 10,11,10,00
    push_row(2'b01, 2'b01, 1'b0, 5, 1'b0, 2, 1'b0);
    push_row(2'b01, 2'b00, 1'b0, 5, 1'b0, 2, 1'b0);
    push_row(2'b00, 2'b00, 1'b0, 5, 1'b1, 2, 1'b0);
    push_seq(2'b11, 2'b00, 4, 1'b0);                     // 2 -> 4
    push_seq(2'b01, 2'b10, 4, 1'b0);                     // entry g0 + exit g1 together
    push_seq(2'b11, 2'b00, 6, 1'b0);                     // 4 -> 6
    push_seq(2'b11, 2'b00, 7, 1'b1);                     // 6 + 2 clamps at 7
    push_seq(2'b01, 2'b00, 7, 1'b1);                     // entry at full dropped
    push_row(2'b00, 2'b00, 1'b1, 1, 1'b1, 7, 1'b0);      // err_clr
    push_seq(2'b00, 2'b11, 5, 1'b0);
    push_seq(2'b00, 2'b11, 3, 1'b0);
    push_seq(2'b00, 2'b11, 1, 1'b0);
    push_seq(2'b00, 2'b11, 0, 1'b1);                     // 1 - 2 clamps at 0
    push_row(2'b00, 2'b00, 1'b1, 1, 1'b1, 0, 1'b0);      // err_clr
    push_seq(2'b00, 2'b01, 0, 1'b1);                     // exit at empty dropped
    push_row(2'b00, 2'b00, 1'b1, 1, 1'b1, 0, 1'b0);      // err_clr

    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].clr, tbl[i].hold);
      if (tbl[i].chk) begin
        check_flags($sformatf("row%0d", i), tbl[i].cnt, tbl[i].e);
        check($sformatf("row%0d_ent0", i), 32'(ent_tot[0]), 32'(tbl[i].ent0));
        check($sformatf("row%0d_ent1", i), 32'(ent_tot[1]), 32'(tbl[i].ent1));
        check($sformatf("row%0d_ext0", i), 32'(ext_tot[0]), 32'(tbl[i].ext0));
        check($sformatf("row%0d_ext1", i), 32'(ext_tot[1]), 32'(tbl[i].ext1));
      end
    end

    // ---- pipeline latency: gate1 entry, closing 00 applied at a falling edge ----
    drive(2'b10, 2'b00, 1'b0, 5);
    drive(2'b10, 2'b10, 1'b0, 5);
    drive(2'b00, 2'b10, 1'b0, 5);
    @(negedge clk);
    sens_a = '0;
    sens_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("lat_edge2_pulse", 32'(entry_pulse), 32'd0);
    check("lat_edge2_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge3_pulse", 32'(entry_pulse), 32'b10);
    check("lat_edge3_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge4_pulse", 32'(entry_pulse), 32'd0);
    check_flags("lat_edge4", 1, 1'b0);

    // ---- reset while gate0 sits in E2 ----
    drive(2'b01, 2'b00, 1'b0, 5);
    drive(2'b01, 2'b01, 1'b0, 5);
    for (int g = 0; g < N; g++) begin
      s_ent[g] = ent_tot[g];
      s_ext[g] = ext_tot[g];
    end
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_flags("midrst", 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b00, 2'b00, 1'b0, 10);
    check_flags("midrst_rel", 0, 1'b0);
    check("midrst_ent0", 32'(ent_tot[0]), 32'(s_ent[0]));
    check("midrst_ent1", 32'(ent_tot[1]), 32'(s_ent[1]));
    check("midrst_ext0", 32'(ext_tot[0]), 32'(s_ext[0]));
    check("midrst_ext1", 32'(ext_tot[1]), 32'(s_ext[1]));

    // ---- fresh entry after reset still counts ----
    drive(2'b01, 2'b00, 1'b0, 5);
    drive(2'b01, 2'b01, 1'b0, 5);
    drive(2'b00, 2'b01, 1'b0, 5);
    drive(2'b00, 2'b00, 1'b0, 5);
    check_flags("post_rst_entry", 1, 1'b0);
    check("post_rst_ent0", 32'(ent_tot[0]), 32'(s_ent[0] + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
